down_counter: RTL and testbench

Loadable down counter with count enable, terminal-count pulse and busy flag. It is the counting-down counterpart of the team's `up_counter` and keeps the same `clk`/`rst`/`ld`/`ldvalue`/`dout` interface. Intended uses are timeouts, delay generation and programmable-interval ticks in the same designs. A small two-state controller tracks whether a count is in progress.

---
 rtl/down_counter.sv | 76 +++++++
 tb/tb_down_counter.sv | 139 +++++++++++++
 2 files changed

// File: rtl/down_counter.sv
// Loadable down counter with count enable, one-cycle terminal-count pulse and busy flag.
// Define DOWN_COUNTER_RELOAD_EN for auto-reload on terminal count; default is one-shot.
module down_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [WIDTH-1:0] ldvalue,
    input  logic             en,
    output logic [WIDTH-1:0] dout,
    output logic             busy,
    output logic             tc
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    localparam logic [WIDTH-1:0] One = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            dout_q   <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            dout_q   <= dout_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        dout_d   = dout_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        if (ld) begin
            dout_d   = ldvalue;
            reload_d = ldvalue;
            state_d  = (ldvalue != '0) ? StRun : StIdle;
        end else begin
            unique case (state_q)
                StIdle: ;
                StRun: begin
                    if (en) begin
                        // In RUN dout is always >= 1, so the else branch is the terminal step.
                        if (dout_q > One) begin
                            dout_d = dout_q - One;
                        end else begin
                            tc_d = 1'b1;
`ifdef DOWN_COUNTER_RELOAD_EN
                            dout_d = reload_q;
`else
                            dout_d  = '0;
                            state_d = StIdle;
`endif
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign dout = dout_q;
    assign busy = (state_q == StRun);
    assign tc   = tc_q;

endmodule

// File: tb/tb_down_counter.sv
// Directed self-checking bench for down_counter (WIDTH=4); follows DOWN_COUNTER_RELOAD_EN.
module tb_down_counter;

    logic       clk;
    logic       rst;
    logic       ld;
    logic [3:0] ldvalue;
    logic       en;
    logic [3:0] dout;
    logic       busy;
    logic       tc;

    int n_checks = 0;
    int n_fail   = 0;

    down_counter #(.WIDTH(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .ld      (ld),
        .ldvalue (ldvalue),
        .en      (en),
        .dout    (dout),
        .busy    (busy),
        .tc      (tc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [3:0] exp_dout, input logic exp_busy,
                       input logic exp_tc);
        n_checks++;
        assert (dout === exp_dout && busy === exp_busy && tc === exp_tc) else begin
            n_fail++;
            $error("FAIL %s: got dout=%0d busy=%b tc=%b, expected dout=%0d busy=%b tc=%b",
                   tag, dout, busy, tc, exp_dout, exp_busy, exp_tc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // 1. Reset held with a pending load
        rst = 1'b0; ld = 1'b1; ldvalue = 4'd9; en = 1'b0;
        #1;
        chk("reset_async", 4'd0, 1'b0, 1'b0);
        step(); chk("reset_c1", 4'd0, 1'b0, 1'b0);
        step(); chk("reset_c2", 4'd0, 1'b0, 1'b0);
        rst = 1'b1; ld = 1'b0; en = 1'b1;
        step(); chk("idle_after_reset", 4'd0, 1'b0, 1'b0);

        // 2. Countdown from 5
        ld = 1'b1; ldvalue = 4'd5; en = 1'b1;
        step(); chk("os_load5", 4'd5, 1'b1, 1'b0);
        ld = 1'b0;
        step(); chk("os_4", 4'd4, 1'b1, 1'b0);
        step(); chk("os_3", 4'd3, 1'b1, 1'b0);
        step(); chk("os_2", 4'd2, 1'b1, 1'b0);
        step(); chk("os_1", 4'd1, 1'b1, 1'b0);
`ifdef DOWN_COUNTER_RELOAD_EN
        step(); chk("ar_wrap5", 4'd5, 1'b1, 1'b1);
        step(); chk("ar_after_wrap", 4'd4, 1'b1, 1'b0);
`else
        step(); chk("os_term0", 4'd0, 1'b0, 1'b1);
        step(); chk("os_hold0", 4'd0, 1'b0, 1'b0);
`endif

        // 3. Enable gating, then a zero load
        ld = 1'b1; ldvalue = 4'd3; en = 1'b1;
        step(); chk("gate_load3", 4'd3, 1'b1, 1'b0);
        ld = 1'b0; en = 1'b1;
        step(); chk("gate_en1", 4'd2, 1'b1, 1'b0);
        en = 1'b0;
        step(); chk("gate_en0", 4'd2, 1'b1, 1'b0);
        en = 1'b1;
        step(); chk("gate_en1b", 4'd1, 1'b1, 1'b0);
`ifdef DOWN_COUNTER_RELOAD_EN
        step(); chk("gate_term", 4'd3, 1'b1, 1'b1);
`else
        step(); chk("gate_term", 4'd0, 1'b0, 1'b1);
`endif
        ld = 1'b1; ldvalue = 4'd0;
        step(); chk("zero_load", 4'd0, 1'b0, 1'b0);
        ld = 1'b0;
        step(); chk("zero_idle", 4'd0, 1'b0, 1'b0);

        // 4. Load colliding with the terminal step
        ld = 1'b1; ldvalue = 4'd8; en = 1'b1;
        step(); chk("mid_load8", 4'd8, 1'b1, 1'b0);
        ld = 1'b0;
        for (int i = 7; i >= 1; i--) begin
            step(); chk("mid_count", 4'(i), 1'b1, 1'b0);
        end
        ld = 1'b1; ldvalue = 4'd6;
        step(); chk("mid_reload6", 4'd6, 1'b1, 1'b0);
        ld = 1'b0;
        step(); chk("mid_after", 4'd5, 1'b1, 1'b0);

        // 5. Load 3, seven enabled cycles
        ld = 1'b1; ldvalue = 4'd3; en = 1'b1;
        step(); chk("seq_c1", 4'd3, 1'b1, 1'b0);
        ld = 1'b0;
        step(); chk("seq_c2", 4'd2, 1'b1, 1'b0);
        step(); chk("seq_c3", 4'd1, 1'b1, 1'b0);
`ifdef DOWN_COUNTER_RELOAD_EN
        step(); chk("seq_c4", 4'd3, 1'b1, 1'b1);
        step(); chk("seq_c5", 4'd2, 1'b1, 1'b0);
        step(); chk("seq_c6", 4'd1, 1'b1, 1'b0);
        step(); chk("seq_c7", 4'd3, 1'b1, 1'b1);
`else
        step(); chk("seq_c4", 4'd0, 1'b0, 1'b1);
        step(); chk("seq_c5", 4'd0, 1'b0, 1'b0);
        step(); chk("seq_c6", 4'd0, 1'b0, 1'b0);
        step(); chk("seq_c7", 4'd0, 1'b0, 1'b0);
`endif

        // 6. Asynchronous reset mid-count
        ld = 1'b1; ldvalue = 4'd12; en = 1'b1;
        step(); chk("ar_load12", 4'd12, 1'b1, 1'b0);
        ld = 1'b0;
        step(); chk("ar_11", 4'd11, 1'b1, 1'b0);
        step(); chk("ar_10", 4'd10, 1'b1, 1'b0);
        step(); chk("ar_9", 4'd9, 1'b1, 1'b0);
        #2 rst = 1'b0;
        #1 chk("async_rst", 4'd0, 1'b0, 1'b0);
        #1 rst = 1'b1;
        step(); chk("post_rst_idle1", 4'd0, 1'b0, 1'b0);
        step(); chk("post_rst_idle2", 4'd0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
